store_rmw_controller: RTL and testbench
=======================================

# store_rmw_controller

Sequencer that executes RISC-V store instructions (sb/sh/sw/sd) against the 64-bit doubleword-wide data memory of the multicycle datapath. It sits between the main control unit and the data memory port. It performs a read-modify-write for sub-doubleword stores and a direct write for sd, merging the narrow store data into the correct byte lanes. It also flags misaligned or invalid stores without touching memory.

## Interface

Parameters:
- MEM_LAT, default 1: memory read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  store request; accepted only in IDLE.
- funct3  in  3  store width: 0=sb, 1=sh, 2=sw, 3=sd, 4..7 invalid.
- addr  in  64  byte address of the store.
- store_data  in  64  rs2 value; only the low 8/16/32/64 bits are used.
- mem_rdata  in  64  memory read data; valid MEM_LAT cycles after mem_rd.
- mem_addr  out  64  doubleword address {addr_q[63:3], 3'b000}.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  64  merged write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  error flag; meaningful only while done=1.

## Operation

- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE: on start=1, latch addr, funct3 and store_data. Evaluate legality:
  - sb: always legal.
  - sh: addr[0]=0.
  - sw: addr[1:0]=0.
  - sd: addr[2:0]=0.
  - funct3 values 4..7 are illegal.
- Transitions out of IDLE:
  - Illegal request -> ERR.
  - Legal sd -> WRITE.
  - Legal sb/sh/sw -> READ.
- READ: mem_rd=1 for exactly one cycle, then -> WAIT.
- WAIT: down-counter loaded with MEM_LAT. Stay until count expires. Capture mem_rdata into old_q on the last WAIT cycle, then -> WRITE.
- WRITE: mem_wr=1 for exactly one cycle, then -> DONE.
  - sd: mem_wdata = store_data_q.
  - sb/sh/sw: mem_wdata = old_q with byte lanes replaced, starting at lane addr_q[2:0]:
    - sb: 1 lane, store_data_q[7:0].
    - sh: 2 lanes, store_data_q[15:0].
    - sw: 4 lanes, store_data_q[31:0].
  - No sign extension; bytes outside the selected lanes keep their old_q values.
- DONE: done=1, misaligned=0, then -> IDLE.
- ERR: done=1, misaligned=1, then -> IDLE. No mem_rd or mem_wr is ever issued for an illegal request.
- start outside IDLE is ignored and not queued. This includes start asserted in DONE or ERR.
- mem_addr is driven from addr_q in every non-IDLE state; it is 0 in IDLE.
- mem_wdata is 0 outside WRITE.

## Timing

- Reset values: state=IDLE; mem_rd, mem_wr, done, misaligned, busy = 0; mem_addr, mem_wdata = 0; all latches cleared.
- Reset asserted in any state returns the block to IDLE on the next edge. Any pending write is abandoned, so no mem_wr is issued after reset.
- All outputs are decoded from the registered state (Moore), so there is no combinational path from start to mem_*.
- start is sampled at edge E0; cycle n is the cycle after edge En.
- sb/sh/sw:
  - READ in cycle 1.
  - WAIT in cycles 2..1+MEM_LAT; mem_rdata is sampled at the end of cycle 1+MEM_LAT.
  - WRITE in cycle 2+MEM_LAT.
  - done in cycle 3+MEM_LAT. With MEM_LAT=1, done is in cycle 4.
- sd: WRITE in cycle 1, done in cycle 2.
- Illegal request: done=1 and misaligned=1 in cycle 1.
- The next request can be accepted in the cycle after done, i.e. at the edge that ends the IDLE cycle.
- Throughput: one store per 4+MEM_LAT cycles for sb/sh/sw, one per 3 cycles for sd.

## Test plan

- sb, MEM_LAT=1: addr=0x1003, data=0xAB, memory holds 0x1122334455667788.
  -> mem_rd in cycle 1; mem_wr in cycle 3 with mem_addr=0x1000 and mem_wdata=0x11223344AB667788; done in cycle 4.
- sh and sw on the same memory word:
  - sh addr=0x1006, data=0xBEEF -> mem_wdata=0xBEEF334455667788.
  - sw addr=0x1004, data=0xDEADBEEF -> mem_wdata=0xDEADBEEF55667788.
- sd addr=0x2008, data=0x0123456789ABCDEF.
  -> no mem_rd; mem_wr in cycle 1 with mem_addr=0x2008 and that data; done in cycle 2.
- Illegal requests: sw at addr=0x1002, then funct3=5.
  -> each produces done=1 and misaligned=1 in cycle 1; mem_rd and mem_wr stay 0 throughout.
- MEM_LAT=3 with sb at addr=0x1000, plus start pulsed during WAIT.
  -> WAIT lasts 3 cycles; mem_wr in cycle 5; done in cycle 6; the extra start is ignored (no second transaction).
- reset asserted during WAIT.
  -> IDLE on the next edge with all outputs 0; no mem_wr appears. A new sd accepted afterwards completes normally.

Source files
------------

// File: rtl/store_rmw_if.sv
// Request and data-memory signals of the store read-modify-write sequencer,
// grouped so the control unit, controller and memory share one bundle.
interface store_rmw_if;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [63:0] mem_rdata;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport slave (
        input  start, funct3, addr, store_data, mem_rdata,
        output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misaligned
    );

    modport master (
        output start, funct3, addr, store_data, mem_rdata,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misaligned
    );
endinterface

// File: rtl/store_rmw_controller.sv
// Executes sb/sh/sw/sd against a 64-bit data memory: read-modify-write for
// narrow stores, direct write for sd, and an error completion for illegal stores.
module store_rmw_controller #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    store_rmw_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [1:0] W_SB = 2'd0;
    localparam logic [1:0] W_SH = 2'd1;
    localparam logic [1:0] W_SD = 2'd3;

    state_e      state_q;
    logic [63:0] addr_q;
    logic [1:0]  width_q;
    logic [63:0] store_data_q;
    logic [63:0] old_q;
    logic [2:0]  cnt_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic        busy_q;
    logic        done_q;
    logic        misaligned_q;
    logic [63:0] merged_d;

    function automatic logic is_legal(input logic [2:0] f3, input logic [2:0] lsb);
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return lsb[0] == 1'b0;
            3'd2:    return lsb[1:0] == 2'b00;
            3'd3:    return lsb == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    // Replace 1/2/4 byte lanes of old starting at lane off; alignment is
    // already guaranteed, so the lane window never wraps past lane 7.
    function automatic logic [63:0] merge_lanes(input logic [63:0] old,
                                                input logic [63:0] data,
                                                input logic [2:0]  off,
                                                input logic [1:0]  width);
        logic [7:0]  bmask;
        logic [63:0] mask;
        logic [63:0] shifted;
        case (width)
            W_SB:    bmask = 8'h01;
            W_SH:    bmask = 8'h03;
            default: bmask = 8'h0F;
        endcase
        bmask   = bmask << off;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{bmask[i]}};
        end
        shifted = data << {off, 3'b000};
        return (old & ~mask) | (shifted & mask);
    endfunction

    always_comb begin
        merged_d = 64'd0;
        if (state_q == S_WRITE) begin
            merged_d = (width_q == W_SD) ? store_data_q
                                         : merge_lanes(old_q, store_data_q, addr_q[2:0], width_q);
        end
    end

    // NOTE: every register here is written with <= so all reads in this block see
    // pre-edge values; blocking assignments would make ordering change behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath latches are cleared too, so no stale address or
            // data from an abandoned store can ever reach the memory outputs.
            state_q      <= S_IDLE;
            addr_q       <= 64'd0;
            width_q      <= 2'd0;
            store_data_q <= 64'd0;
            old_q        <= 64'd0;
            cnt_q        <= 3'd0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q       <= bus.addr;
                        width_q      <= bus.funct3[1:0];
                        store_data_q <= bus.store_data;
                        busy_q       <= 1'b1;
                        if (!is_legal(bus.funct3, bus.addr[2:0])) begin
                            state_q      <= S_ERR;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else if (bus.funct3[1:0] == W_SD) begin
                            state_q  <= S_WRITE;
                            mem_wr_q <= 1'b1;
                        end else begin
                            state_q  <= S_READ;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                    cnt_q   <= 3'(MEM_LAT);
                end
                S_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        old_q    <= bus.mem_rdata;
                        state_q  <= S_WRITE;
                        mem_wr_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.misaligned = misaligned_q;
    assign bus.mem_addr   = busy_q ? {addr_q[63:3], 3'b000} : 64'd0;
    assign bus.mem_wdata  = merged_d;

endmodule

// File: tb/tb_store_rmw_controller.sv
// Directed bench for store_rmw_controller: a MEM_LAT=1 and a MEM_LAT=3 instance
// checked cycle by cycle against the documented store timeline.
module tb_store_rmw_controller;

    typedef struct {
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] mem_word;
        logic        legal;
        logic [63:0] exp_wdata;
    } vec_t;

    localparam logic [63:0] GARBAGE = 64'hA5A5_5A5A_C3C3_3C3C;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [63:0] mem_word;
    logic [0:0]  hist_a = '0;
    logic [2:0]  hist_b = '0;

    int errors = 0;
    int checks = 0;

    store_rmw_if bus_a ();
    store_rmw_if bus_b ();

    store_rmw_controller #(.MEM_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    store_rmw_controller #(.MEM_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    always #5 clk = ~clk;

    assign bus_a.start      = start & ~sel;
    assign bus_b.start      = start & sel;
    assign bus_a.funct3     = funct3;
    assign bus_b.funct3     = funct3;
    assign bus_a.addr       = addr;
    assign bus_b.addr       = addr;
    assign bus_a.store_data = store_data;
    assign bus_b.store_data = store_data;

    // Memory read data is valid only in the MEM_LAT-th cycle after mem_rd.
    always @(posedge clk) begin
        hist_a <= bus_a.mem_rd;
        hist_b <= {hist_b[1:0], bus_b.mem_rd};
    end
    assign bus_a.mem_rdata = hist_a[0] ? mem_word : GARBAGE;
    assign bus_b.mem_rdata = hist_b[2] ? mem_word : GARBAGE;

    logic        o_rd, o_wr, o_busy, o_done, o_mis;
    logic [63:0] o_addr, o_wdata;
    assign o_rd    = sel ? bus_b.mem_rd     : bus_a.mem_rd;
    assign o_wr    = sel ? bus_b.mem_wr     : bus_a.mem_wr;
    assign o_busy  = sel ? bus_b.busy       : bus_a.busy;
    assign o_done  = sel ? bus_b.done       : bus_a.done;
    assign o_mis   = sel ? bus_b.misaligned : bus_a.misaligned;
    assign o_addr  = sel ? bus_b.mem_addr   : bus_a.mem_addr;
    assign o_wdata = sel ? bus_b.mem_wdata  : bus_a.mem_wdata;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, " rd"}, 64'(o_rd), 64'd0);
        check({tag, " wr"}, 64'(o_wr), 64'd0);
        check({tag, " busy"}, 64'(o_busy), 64'd0);
        check({tag, " done"}, 64'(o_done), 64'd0);
        check({tag, " mis"}, 64'(o_mis), 64'd0);
        check({tag, " addr"}, o_addr, 64'd0);
        check({tag, " wdata"}, o_wdata, 64'd0);
    endtask

    // Called just after a negedge in an idle cycle; ends on the negedge of the
    // idle cycle following done, so calls can be chained back to back.
    task automatic run_txn(input vec_t v, input int lat, input bit extra_start, input string tag);
        bit is_sd;
        int ncyc;
        int wr_cyc;
        logic [63:0] aligned;
        is_sd   = v.legal && (v.funct3 == 3'd3);
        ncyc    = !v.legal ? 1 : (is_sd ? 2 : 3 + lat);
        wr_cyc  = is_sd ? 1 : 2 + lat;
        aligned = {v.addr[63:3], 3'b000};
        mem_word   = v.mem_word;
        funct3     = v.funct3;
        addr       = v.addr;
        store_data = v.data;
        start      = 1'b1;
        for (int c = 1; c <= ncyc + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("%s c%0d busy", tag, c), 64'(o_busy), 64'(c <= ncyc));
            check($sformatf("%s c%0d rd", tag, c), 64'(o_rd), 64'(v.legal && !is_sd && c == 1));
            check($sformatf("%s c%0d wr", tag, c), 64'(o_wr), 64'(v.legal && c == wr_cyc));
            check($sformatf("%s c%0d done", tag, c), 64'(o_done), 64'(c == ncyc));
            check($sformatf("%s c%0d mis", tag, c), 64'(o_mis), 64'(!v.legal && c == 1));
            check($sformatf("%s c%0d addr", tag, c), o_addr, (c <= ncyc) ? aligned : 64'd0);
            check($sformatf("%s c%0d wdata", tag, c), o_wdata,
                  (v.legal && c == wr_cyc) ? v.exp_wdata : 64'd0);
            if (extra_start && (c == 3 || c == ncyc)) begin
                funct3     = 3'd3;
                addr       = 64'h4000;
                store_data = 64'hFFFF_0000_FFFF_0000;
                start      = 1'b1;
            end
        end
    endtask

    vec_t vecs [13];
    vec_t v;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{3'd0, 64'h1003, 64'hAB,                 64'h1122334455667788, 1'b1, 64'h11223344AB667788};
        vecs[1]  = '{3'd1, 64'h1006, 64'hBEEF,               64'h1122334455667788, 1'b1, 64'hBEEF334455667788};
        vecs[2]  = '{3'd2, 64'h1004, 64'hDEADBEEF,           64'h1122334455667788, 1'b1, 64'hDEADBEEF55667788};
        vecs[3]  = '{3'd3, 64'h2008, 64'h0123456789ABCDEF,   64'h1122334455667788, 1'b1, 64'h0123456789ABCDEF};
        vecs[4]  = '{3'd2, 64'h1002, 64'h12345678,           64'h1122334455667788, 1'b0, 64'd0};
        vecs[5]  = '{3'd5, 64'h1000, 64'h12345678,           64'h1122334455667788, 1'b0, 64'd0};
        vecs[6]  = '{3'd0, 64'h1000, 64'hFFFFFFFFFFFFFF5A,   64'h1122334455667788, 1'b1, 64'h112233445566775A};
        vecs[7]  = '{3'd1, 64'h1001, 64'h1234,               64'h1122334455667788, 1'b0, 64'd0};
        vecs[8]  = '{3'd3, 64'h2004, 64'h1,                  64'h1122334455667788, 1'b0, 64'd0};
        vecs[9]  = '{3'd1, 64'h1002, 64'hFFFFFFFFFFFF1234,   64'h1122334455667788, 1'b1, 64'h1122334412347788};
        vecs[10] = '{3'd0, 64'h1007, 64'hCD,                 64'h1122334455667788, 1'b1, 64'hCD22334455667788};
        vecs[11] = '{3'd4, 64'h3000, 64'h99,                 64'h1122334455667788, 1'b0, 64'd0};
        vecs[12] = '{3'd2, 64'h1000, 64'hFFFFFFFFCAFEF00D,   64'h1122334455667788, 1'b1, 64'h11223344CAFEF00D};

        reset = 1'b1; sel = 1'b0; start = 1'b0;
        funct3 = 3'd0; addr = 64'd0; store_data = 64'd0; mem_word = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_idle("reset lat1");
        sel = 1'b1;
        #1;
        check_all_idle("reset lat3");
        sel = 1'b0;
        reset = 1'b0;

        // Back-to-back table on the MEM_LAT=1 instance.
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], 1, 1'b0, $sformatf("vec%0d", i));
        end

        // MEM_LAT=3 sb with start pulsed in WAIT and in DONE; neither is taken.
        sel = 1'b1;
        @(negedge clk);
        v = '{3'd0, 64'h1000, 64'h42, 64'h1122334455667788, 1'b1, 64'h1122334455667742};
        run_txn(v, 3, 1'b1, "lat3_sb");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_all_idle($sformatf("lat3 post c%0d", c));
        end

        // Reset during WAIT abandons the store.
        funct3 = 3'd0; addr = 64'h1005; store_data = 64'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_wait rd c1", 64'(o_rd), 64'd1);
        @(negedge clk);
        check("rst_wait busy c2", 64'(o_busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_idle("rst_wait after reset");
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst_wait no wr c%0d", c), 64'(o_wr), 64'd0);
            check($sformatf("rst_wait idle c%0d", c), 64'(o_busy), 64'd0);
        end
        v = '{3'd3, 64'h2008, 64'h0123456789ABCDEF, 64'h0, 1'b1, 64'h0123456789ABCDEF};
        run_txn(v, 3, 1'b0, "post_rst_sd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
